// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: the WSel/RSel control codes,
// FSM states, access widths and small decode helpers.
package dmem_lsu_pkg;

    // Store width select (WSel)
    localparam logic [1:0] WselByte = 2'b00;
    localparam logic [1:0] WselHalf = 2'b01;
    localparam logic [1:0] WselWord = 2'b10;
    localparam logic [1:0] WselNone = 2'b11;

    // Load type select (RSel); any code not listed is treated as no load
    localparam logic [2:0] RselLb   = 3'b000;
    localparam logic [2:0] RselLh   = 3'b010;
    localparam logic [2:0] RselLw   = 3'b011;
    localparam logic [2:0] RselLbu  = 3'b100;
    localparam logic [2:0] RselLhu  = 3'b101;
    localparam logic [2:0] RselNone = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        WidthByte = 2'b00,
        WidthHalf = 2'b01,
        WidthWord = 2'b10
    } width_e;

    function automatic logic rsel_is_load(input logic [2:0] rsel);
        return (rsel == RselLb) || (rsel == RselLh) || (rsel == RselLw) ||
               (rsel == RselLbu) || (rsel == RselLhu);
    endfunction

    function automatic width_e wsel_width(input logic [1:0] wsel);
        case (wsel)
            WselByte: return WidthByte;
            WselHalf: return WidthHalf;
            default:  return WidthWord;
        endcase
    endfunction

    function automatic width_e rsel_width(input logic [2:0] rsel);
        case (rsel)
            RselLb, RselLbu: return WidthByte;
            RselLh, RselLhu: return WidthHalf;
            default:         return WidthWord;
        endcase
    endfunction

    function automatic logic is_aligned(input width_e w, input logic [1:0] off);
        case (w)
            WidthHalf: return !off[0];
            WidthWord: return off == 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input width_e w, input logic [1:0] off);
        case (w)
            WidthByte: return 4'b0001 << off;
            WidthHalf: return 4'b0011 << {off[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data so every enabled lane carries it
    function automatic logic [31:0] lane_wdata(input width_e w, input logic [31:0] d);
        case (w)
            WidthByte: return {4{d[7:0]}};
            WidthHalf: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a returned bus word.
module lsu_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  width_e      width,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend to 32 bits
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data    = rdata;
        case (width)
            WidthByte: data = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            WidthHalf: data = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: decodes the memory-stage access, checks alignment,
// runs a request/grant/read-valid bus handshake and returns extended load data.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              MemRW,
    input  logic [1:0]        WSel,
    input  logic [2:0]        RSel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              ld_valid_q, ld_valid_d;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    width_e            width_q;
    logic              unsigned_q;
    logic [1:0]        off_q;
    logic [31:0]       ld_data_q;
    logic [31:0]       ld_ext;

    logic   is_store, is_load, access, aligned, start;
    width_e acc_width;
    logic   acc_unsigned;

    // Decode the presented access; done_q masks the instruction that just completed
    // and is still held on the inputs for the one cycle stall drops.
    always_comb begin
        is_store     = MemRW && (WSel != WselNone);
        is_load      = !MemRW && rsel_is_load(RSel);
        acc_width    = is_store ? wsel_width(WSel) : rsel_width(RSel);
        acc_unsigned = (RSel == RselLbu) || (RSel == RselLhu);
        aligned      = is_aligned(acc_width, addr[1:0]);
        access       = !rst && ex_valid && (is_store || is_load) && (state_q == StIdle) && !done_q;
        start        = access && aligned;
        misalign     = access && !aligned;
        stall        = !rst && (start || (state_q == StReq) || (state_q == StWait));
    end

    // Next-state logic for the bus handshake
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        ld_valid_d = 1'b0;
        unique case (state_q)
            StIdle: if (start) state_d = StReq;
            StReq: begin
                if (bus_gnt) begin
                    state_d = we_q ? StIdle : StWait;
                    done_d  = we_q;
                end
            end
            StWait: begin
                if (bus_rvalid) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    ld_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, captured request and load result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            ld_valid_q <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0;
            wdata_q    <= 32'b0;
            we_q       <= 1'b0;
            width_q    <= WidthByte;
            unsigned_q <= 1'b0;
            off_q      <= 2'b0;
            ld_data_q  <= 32'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            ld_valid_q <= ld_valid_d;
            if (start) begin
                addr_q     <= {addr[ADDR_W-1:2], 2'b00};
                be_q       <= byte_enable(acc_width, addr[1:0]);
                wdata_q    <= lane_wdata(acc_width, wdata);
                we_q       <= is_store;
                width_q    <= acc_width;
                unsigned_q <= acc_unsigned;
                off_q      <= addr[1:0];
            end
            if ((state_q == StWait) && bus_rvalid) begin
                ld_data_q <= ld_ext;
            end
        end
    end

    lsu_load_align u_load_align (
        .rdata       (bus_rdata),
        .off         (off_q),
        .width       (width_q),
        .is_unsigned (unsigned_q),
        .data        (ld_ext)
    );

    assign bus_req   = (state_q == StReq);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign ld_data   = ld_data_q;
    assign ld_valid  = ld_valid_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a vector table of single accesses with immediate
// handshakes, plus hand-written sequences for delayed handshakes and reset mid-transfer.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam logic [1:0] KAcc = 2'd0;
    localparam logic [1:0] KMis = 2'd1;
    localparam logic [1:0] KNop = 2'd2;

    typedef struct packed {
        logic        memrw;
        logic [1:0]  wsel;
        logic [2:0]  rsel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  kind;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [31:0] ld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, MemRW;
    logic [1:0]  WSel;
    logic [2:0]  RSel;
    logic [31:0] addr, wdata;
    logic        stall, ld_valid, misalign, bus_req, bus_we;
    logic [31:0] ld_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_ld;
    vec_t vecs[18];

    dmem_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .MemRW      (MemRW),
        .WSel       (WSel),
        .RSel       (RSel),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .misalign   (misalign),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic memrw, input logic [1:0] wsel, input logic [2:0] rsel,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [1:0] kind,
                                input logic [3:0] be, input logic [31:0] bwd,
                                input logic [31:0] ba, input logic [31:0] ld);
        vec_t v;
        v.memrw = memrw; v.wsel = wsel; v.rsel = rsel; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.kind = kind; v.be = be; v.bwdata = bwd; v.baddr = ba; v.ld = ld;
        return v;
    endfunction

    task automatic drive_access(input logic memrw, input logic [1:0] wsel, input logic [2:0] rsel,
                                input logic [31:0] a, input logic [31:0] wd);
        ex_valid = 1'b1; MemRW = memrw; WSel = wsel; RSel = rsel; addr = a; wdata = wd;
    endtask

    // One access from IDLE with grant and read-valid on their first opportunity
    task automatic apply(input int i, input vec_t v);
        drive_access(v.memrw, v.wsel, v.rsel, v.addr, v.wdata);
        #1;
        if (v.kind == KMis || v.kind == KNop) begin
            check($sformatf("v%0d misalign", i), 32'(misalign), 32'(v.kind == KMis));
            check($sformatf("v%0d stall", i), 32'(stall), 32'd0);
            check($sformatf("v%0d bus_req", i), 32'(bus_req), 32'd0);
            tick();
            ex_valid = 1'b0;
            #1;
            check($sformatf("v%0d misalign_after", i), 32'(misalign), 32'd0);
            check($sformatf("v%0d bus_req_after", i), 32'(bus_req), 32'd0);
            check($sformatf("v%0d ld_data_held", i), ld_data, last_ld);
            tick();
            return;
        end
        check($sformatf("v%0d stall_idle", i), 32'(stall), 32'd1);
        check($sformatf("v%0d bus_req_idle", i), 32'(bus_req), 32'd0);
        tick();
        bus_gnt = 1'b1;
        #1;
        check($sformatf("v%0d bus_req", i), 32'(bus_req), 32'd1);
        check($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(v.memrw));
        check($sformatf("v%0d bus_addr", i), bus_addr, v.baddr);
        check($sformatf("v%0d bus_be", i), 32'(bus_be), 32'(v.be));
        if (v.memrw) check($sformatf("v%0d bus_wdata", i), bus_wdata, v.bwdata);
        check($sformatf("v%0d stall_req", i), 32'(stall), 32'd1);
        tick();
        bus_gnt = 1'b0;
        if (!v.memrw) begin
            bus_rvalid = 1'b1;
            bus_rdata  = v.rdata;
            #1;
            check($sformatf("v%0d bus_req_wait", i), 32'(bus_req), 32'd0);
            check($sformatf("v%0d stall_wait", i), 32'(stall), 32'd1);
            tick();
            bus_rvalid = 1'b0;
            bus_rdata  = 32'h0;
            #1;
            check($sformatf("v%0d ld_valid", i), 32'(ld_valid), 32'd1);
            check($sformatf("v%0d ld_data", i), ld_data, v.ld);
            last_ld = v.ld;
        end else begin
            #1;
            check($sformatf("v%0d ld_data_held", i), ld_data, last_ld);
        end
        check($sformatf("v%0d stall_done", i), 32'(stall), 32'd0);
        check($sformatf("v%0d bus_req_done", i), 32'(bus_req), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        check($sformatf("v%0d ld_valid_pulse", i), 32'(ld_valid), 32'd0);
        check($sformatf("v%0d bus_req_idle2", i), 32'(bus_req), 32'd0);
        tick();
    endtask

    initial begin
        vecs[0]  = mk(1, WselWord, RselNone, 32'h100, 32'hDEADBEEF, 0, KAcc, 4'hF, 32'hDEADBEEF, 32'h100, 0);
        vecs[1]  = mk(1, WselByte, RselNone, 32'h103, 32'h000000A5, 0, KAcc, 4'h8, 32'hA5A5A5A5, 32'h100, 0);
        vecs[2]  = mk(1, WselHalf, RselNone, 32'h102, 32'h00001234, 0, KAcc, 4'hC, 32'h12341234, 32'h100, 0);
        vecs[3]  = mk(1, WselByte, RselNone, 32'h001, 32'h00000077, 0, KAcc, 4'h2, 32'h77777777, 32'h000, 0);
        vecs[4]  = mk(0, WselNone, RselLb,  32'h102, 0, 32'h0080FF00, KAcc, 4'h4, 0, 32'h100, 32'hFFFFFF80);
        vecs[5]  = mk(0, WselNone, RselLbu, 32'h102, 0, 32'h0080FF00, KAcc, 4'h4, 0, 32'h100, 32'h00000080);
        vecs[6]  = mk(0, WselNone, RselLh,  32'h102, 0, 32'h80011234, KAcc, 4'hC, 0, 32'h100, 32'hFFFF8001);
        vecs[7]  = mk(0, WselNone, RselLhu, 32'h102, 0, 32'h80011234, KAcc, 4'hC, 0, 32'h100, 32'h00008001);
        vecs[8]  = mk(0, WselNone, RselLh,  32'h100, 0, 32'h80017FFF, KAcc, 4'h3, 0, 32'h100, 32'h00007FFF);
        vecs[9]  = mk(0, WselNone, RselLw,  32'h104, 0, 32'hCAFEF00D, KAcc, 4'hF, 0, 32'h104, 32'hCAFEF00D);
        vecs[10] = mk(0, WselNone, RselLb,  32'h101, 0, 32'h00007F00, KAcc, 4'h2, 0, 32'h100, 32'h0000007F);
        vecs[11] = mk(0, WselNone, RselLh,  32'h101, 0, 0, KMis, 0, 0, 0, 0);
        vecs[12] = mk(1, WselWord, RselNone, 32'h102, 32'h11111111, 0, KMis, 0, 0, 0, 0);
        vecs[13] = mk(0, WselNone, RselLw,  32'h103, 0, 0, KMis, 0, 0, 0, 0);
        vecs[14] = mk(1, WselHalf, RselNone, 32'h003, 32'h2222, 0, KMis, 0, 0, 0, 0);
        vecs[15] = mk(0, WselNone, RselNone, 32'h103, 0, 0, KNop, 0, 0, 0, 0);
        vecs[16] = mk(0, WselNone, 3'b001,   32'h101, 0, 0, KNop, 0, 0, 0, 0);
        vecs[17] = mk(1, WselNone, RselNone, 32'h102, 32'h3333, 0, KNop, 0, 0, 0, 0);

        rst = 1'b1; ex_valid = 1'b0; MemRW = 1'b0; WSel = WselNone; RSel = RselNone;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        last_ld = 32'h0;
        tick();
        tick();
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst ld_valid", 32'(ld_valid), 32'd0);
        check("rst misalign", 32'(misalign), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        check("rst ld_data", ld_data, 32'h0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst bus_wdata", bus_wdata, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) apply(i, vecs[i]);

        // LW with grant after 3 idle REQ cycles and read data 2 cycles into WAIT;
        // stray rvalid in IDLE/REQ and stray gnt in WAIT must be ignored.
        drive_access(0, WselNone, RselLw, 32'h200, 32'h0);
        bus_rvalid = 1'b1;
        #1;
        check("dly stall_idle", 32'(stall), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            bus_gnt = (c == 3);
            #1;
            check($sformatf("dly req%0d bus_req", c), 32'(bus_req), 32'd1);
            check($sformatf("dly req%0d bus_addr", c), bus_addr, 32'h200);
            check($sformatf("dly req%0d bus_be", c), 32'(bus_be), 32'hF);
            check($sformatf("dly req%0d stall", c), 32'(stall), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            bus_gnt    = (c != 2);
            bus_rvalid = (c == 2);
            bus_rdata  = 32'h13572468;
            #1;
            check($sformatf("dly wait%0d bus_req", c), 32'(bus_req), 32'd0);
            check($sformatf("dly wait%0d stall", c), 32'(stall), 32'd1);
            check($sformatf("dly wait%0d ld_valid", c), 32'(ld_valid), 32'd0);
        end
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        check("dly ld_valid", 32'(ld_valid), 32'd1);
        check("dly ld_data", ld_data, 32'h13572468);
        check("dly stall_done", 32'(stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        check("dly ld_valid_pulse", 32'(ld_valid), 32'd0);
        tick();

        // Reset in WAIT, then a late rvalid
        drive_access(0, WselNone, RselLw, 32'h300, 32'h0);
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; rst = 1'b1; ex_valid = 1'b0;
        tick();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        #1;
        check("rstw bus_req", 32'(bus_req), 32'd0);
        check("rstw stall", 32'(stall), 32'd0);
        check("rstw ld_valid", 32'(ld_valid), 32'd0);
        check("rstw ld_data", ld_data, 32'h0);
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        check("rstw late ld_valid", 32'(ld_valid), 32'd0);
        check("rstw late ld_data", ld_data, 32'h0);
        tick();

        // Reset in REQ abandons the request
        drive_access(1, WselWord, RselNone, 32'h400, 32'h55AA55AA);
        tick();
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        rst = 1'b0; bus_gnt = 1'b1;
        #1;
        check("rstr bus_req", 32'(bus_req), 32'd0);
        check("rstr stall", 32'(stall), 32'd0);
        tick();
        bus_gnt = 1'b0;
        #1;
        check("rstr bus_req_after", 32'(bus_req), 32'd0);
        last_ld = 32'h0;

        // Unit is usable again after reset
        apply(5, vecs[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of addr and bus_addr.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  pipeline presents a decoded memory-stage instruction.
REQ-005 MemRW  in  1  1=store, 0=load/none.
REQ-006 WSel  in  2  store width: 00 byte, 01 half, 10 word, 11 no store.
REQ-007 RSel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 no load; other codes = no load.
REQ-008 addr  in  ADDR_W  byte address (ALU result).
REQ-009 wdata  in  32  store data (rs2), right-justified.
REQ-010 stall  out  1  freeze pipeline; inputs SHALL be held stable while 1.
REQ-011 ld_data  out  32  extended load result, valid when ld_valid=1.
REQ-012 ld_valid  out  1  one-cycle load-complete pulse.
REQ-013 misalign  out  1  one-cycle misaligned-access pulse.
REQ-014 bus_req / bus_we  out  1 / 1  bus request; write when 1.
REQ-015 bus_addr  out  ADDR_W  word-aligned address (bits [1:0]=00).
REQ-016 bus_be / bus_wdata  out  4 / 32  byte enables; lane-positioned write data.
REQ-017 bus_gnt / bus_rvalid / bus_rdata  in  1 / 1 / 32  request accepted; read data valid; read data.

Function
REQ-018 Access decode: store = MemRW=1 and WSel!=11; load = MemRW=0 and RSel in {000,010,011,100,101}; otherwise no-op (no bus activity, no stall).
REQ-019 Alignment: half SHALL require addr[0]=0; word SHALL require addr[1:0]=00; byte always aligned.
REQ-020 Misaligned access in IDLE: misalign=1 for that cycle only, no bus request, stall=0, state stays IDLE.
REQ-021 FSM states IDLE, REQ, WAIT; IDLE->REQ on ex_valid and aligned access, registering addr, width, type, MemRW, wdata.
REQ-022 REQ: bus_req=1 with stable bus_we/addr/be/wdata until bus_gnt; store REQ->IDLE on gnt; load REQ->WAIT on gnt.
REQ-023 WAIT: bus_req=0; on bus_rvalid capture extended data into ld_data, ld_valid=1 next cycle, ->IDLE.
REQ-024 stall SHALL be 1 combinationally in IDLE when an aligned access is presented, and 1 throughout REQ and WAIT; 0 in the cycle ld_valid=1.
REQ-025 Minimum latency: store 2 stall cycles (gnt in first REQ cycle); load 3 stall cycles with ld_valid in 4th cycle (gnt and rvalid each on first opportunity).
REQ-026 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-027 bus_wdata: byte replicated in all 4 lanes; half replicated in both halves; word unchanged.
REQ-028 Load extract: lane selected by registered addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 bus_rvalid in IDLE or REQ SHALL be ignored; bus_gnt outside REQ SHALL be ignored.
REQ-030 ld_data SHALL hold its last value until the next load completes.

Reset
REQ-031 rst=1 SHALL force IDLE and clear bus_req, bus_we, bus_be, ld_valid, misalign, stall, and ld_data, bus_addr, bus_wdata to 0 on the next edge.
REQ-032 rst during REQ or WAIT SHALL abandon the transaction; bus_req SHALL be 0 the cycle after rst; a late bus_rvalid SHALL not produce ld_valid.

Structure
REQ-033 Shared package SHALL hold WSel/RSel encodings, FSM state encoding, and access-width enum; the control unit SHALL use the same WSel/RSel constants.
REQ-034 Load lane select and extension SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-035 SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> bus_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; stall 2 cycles.
REQ-036 SB addr=0x103, wdata=0x000000A5 -> be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
REQ-037 LB addr=0x102, rdata=0x0080FF00 -> ld_data=0xFFFFFF80; same with LBU -> 0x00000080; ld_valid single pulse.
REQ-038 LH addr=0x101 -> misalign=1 one cycle, bus_req never asserted, stall=0.
REQ-039 LW with gnt delayed 3 cycles and rvalid delayed 2 -> bus_req held stable 4 cycles, stall continuous until ld_valid, ld_data=bus_rdata.
REQ-040 rst asserted in WAIT, rvalid arrives next cycle -> IDLE, ld_valid stays 0, bus_req 0, stall 0.
